// File: rtl/game_progress_fsm.sv
// Game-progression controller: sequences levels, worlds and lives through timed banner
// phases, with edge-detected pass/fail/start inputs and a restart path from terminal states.
module game_progress_fsm #(
  parameter int unsigned NUM_WORLDS       = 2,
  parameter int unsigned LEVELS_PER_WORLD = 5,
  parameter int unsigned LIVES_INIT       = 3,
  parameter int unsigned BANNER_CYCLES    = 4,
  localparam int unsigned LW = (LEVELS_PER_WORLD <= 2) ? 1 : $clog2(LEVELS_PER_WORLD),
  localparam int unsigned WW = (NUM_WORLDS <= 2) ? 1 : $clog2(NUM_WORLDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          level_passed,
  input  logic          level_failed,
  output logic [LW-1:0] level,
  output logic [WW-1:0] world,
  output logic [3:0]    lives,
  output logic [2:0]    state,
  output logic          playing,
  output logic          banner
);

  localparam int unsigned CW = (BANNER_CYCLES <= 2) ? 1 : $clog2(BANNER_CYCLES);

  localparam logic [LW-1:0] LvlMax    = LW'(LEVELS_PER_WORLD - 1);
  localparam logic [WW-1:0] WldMax    = WW'(NUM_WORLDS - 1);
  localparam logic [CW-1:0] CntMax    = CW'(BANNER_CYCLES - 1);
  localparam logic [3:0]    LivesInit = 4'(LIVES_INIT);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StPlay     = 3'd1,
    StWinLevel = 3'd2,
    StWinWorld = 3'd3,
    StWinGame  = 3'd4,
    StLoseLife = 3'd5,
    StGameOver = 3'd6
  } state_e;

  state_e        r_state, w_state_d;
  logic [LW-1:0] r_level, w_level_d;
  logic [WW-1:0] r_world, w_world_d;
  logic [3:0]    r_lives, w_lives_d;
  logic [CW-1:0] r_cnt, w_cnt_d;
  logic          r_playing, w_playing_d;
  logic          r_banner, w_banner_d;
  logic          r_start_q, r_pass_q, r_fail_q;

  logic w_start_edge, w_pass_edge, w_fail_edge;

  assign w_start_edge = start & ~r_start_q;
  assign w_pass_edge  = level_passed & ~r_pass_q;
  assign w_fail_edge  = level_failed & ~r_fail_q;

  // State register, including registered copies of the decoded flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_level   <= '0;
      r_world   <= '0;
      r_lives   <= LivesInit;
      r_cnt     <= '0;
      r_playing <= 1'b0;
      r_banner  <= 1'b0;
      r_start_q <= 1'b0;
      r_pass_q  <= 1'b0;
      r_fail_q  <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_level   <= w_level_d;
      r_world   <= w_world_d;
      r_lives   <= w_lives_d;
      r_cnt     <= w_cnt_d;
      r_playing <= w_playing_d;
      r_banner  <= w_banner_d;
      r_start_q <= start;
      r_pass_q  <= level_passed;
      r_fail_q  <= level_failed;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_level_d = r_level;
    w_world_d = r_world;
    w_lives_d = r_lives;
    w_cnt_d   = '0;
    case (r_state)
      StIdle: begin
        w_level_d = '0;
        w_world_d = '0;
        w_lives_d = LivesInit;
        if (start) begin
          w_state_d = StPlay;
        end
      end
      StPlay: begin
        // A pass edge takes priority; a coincident fail edge is dropped.
        if (w_pass_edge) begin
          if (r_level < LvlMax) begin
            w_state_d = StWinLevel;
          end else if (r_world < WldMax) begin
            w_state_d = StWinWorld;
          end else begin
            w_state_d = StWinGame;
          end
        end else if (w_fail_edge) begin
          if (r_lives > 4'd1) begin
            w_lives_d = r_lives - 4'd1;
            w_state_d = StLoseLife;
          end else begin
            w_lives_d = '0;
            w_state_d = StGameOver;
          end
        end
      end
      StWinLevel, StWinWorld, StLoseLife: begin
        if (r_cnt == CntMax) begin
          w_state_d = StPlay;
          if (r_state == StWinLevel) begin
            w_level_d = r_level + LW'(1);
          end else if (r_state == StWinWorld) begin
            w_level_d = '0;
            w_world_d = r_world + WW'(1);
          end
        end else begin
          w_cnt_d = r_cnt + CW'(1);
        end
      end
      StWinGame, StGameOver: begin
        // Progress is reset on the way out so IDLE already shows a fresh game.
        if (w_start_edge) begin
          w_state_d = StIdle;
          w_level_d = '0;
          w_world_d = '0;
          w_lives_d = LivesInit;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    w_playing_d = (w_state_d == StPlay);
    w_banner_d  = (w_state_d == StWinLevel) || (w_state_d == StWinWorld) ||
                  (w_state_d == StLoseLife);
  end

  assign level   = r_level;
  assign world   = r_world;
  assign lives   = r_lives;
  assign state   = r_state;
  assign playing = r_playing;
  assign banner  = r_banner;

endmodule

// File: doc/game_progress_fsm.md
# game_progress_fsm

Parametrised game-progression controller: tracks level, world and remaining lives, sequences the win-level, win-world, win-game, lose-life and game-over phases, and holds each phase for a fixed banner time. Sits between the per-level gameplay logic, which raises `level_passed` / `level_failed`, and the display/level-loading logic, which consumes `level`, `world`, `lives` and `state`. Supersedes the single-world, no-lives progression FSM, and adds edge-detected inputs, lives and a restart path.

## Interface
- `NUM_WORLDS`, default 2: worlds per game; must be ≥1.
- `LEVELS_PER_WORLD`, default 5: levels per world; must be ≥1.
- `LIVES_INIT`, default 3: lives at game start; range 1..15.
- `BANNER_CYCLES`, default 4: cycles each banner state is held; must be ≥1.
- Derived: `LW = max(1, clog2(LEVELS_PER_WORLD))`, `WW = max(1, clog2(NUM_WORLDS))`.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `start`  in  1  start/restart request; level-sensitive in IDLE, rising-edge-sensitive in terminal states.
- `level_passed`  in  1  rising edge = current level cleared.
- `level_failed`  in  1  rising edge = current level failed.
- `level`  out  LW  current level index within the world, 0-based.
- `world`  out  WW  current world index, 0-based.
- `lives`  out  4  remaining lives.
- `state`  out  3  encoding: IDLE=0, PLAY=1, WIN_LEVEL=2, WIN_WORLD=3, WIN_GAME=4, LOSE_LIFE=5, GAME_OVER=6.
- `playing`  out  1  high only when in PLAY.
- `banner`  out  1  high in WIN_LEVEL, WIN_WORLD and LOSE_LIFE.

## Operation
- Reset (`reset`=0): state=IDLE, level=0, world=0, lives=`LIVES_INIT`, banner counter=0, and all input-history flops=0. Reset is asynchronous and can occur in any state.
- Edge detection: each of `start`, `level_passed` and `level_failed` has a history flop. An edge is defined as `in & ~in_q`, where `in_q` is the input registered each cycle in every state. A level held high produces exactly one edge.
- IDLE: holds level=0, world=0, lives=`LIVES_INIT`. If `start`=1 (level), next state is PLAY.
- PLAY, on a pass edge:
  - If level < `LEVELS_PER_WORLD`-1, go to WIN_LEVEL.
  - Otherwise, if world < `NUM_WORLDS`-1, go to WIN_WORLD.
  - Otherwise, go to WIN_GAME.
- PLAY, on a fail edge:
  - If lives > 1, decrement lives and go to LOSE_LIFE.
  - Otherwise, set lives to 0 and go to GAME_OVER.
- Simultaneous pass and fail edges: pass wins and the fail edge is discarded.
- Banner states (WIN_LEVEL, WIN_WORLD, LOSE_LIFE):
  - The counter clears on entry and increments every cycle.
  - When counter = `BANNER_CYCLES`-1, the next state is PLAY.
  - On that exit edge: WIN_LEVEL sets level+1; WIN_WORLD sets level=0 and world+1; LOSE_LIFE leaves level and world unchanged (the level is retried).
- WIN_GAME and GAME_OVER are terminal: level, world and lives are frozen. A `start` rising edge moves to IDLE.
- Pass/fail edges outside PLAY are ignored, not queued. History flops still update, so an input held high across a banner produces no edge later.
- Arithmetic: level and world never exceed their maxima, because the guards above prevent wrap. Lives never underflow below 0.

## Timing
- All outputs are registered and change only on the `clk` rising edge, or asynchronously on reset assertion.
- Pass/fail latency: if an input rises before edge k, state changes after edge k (1 cycle).
- Banner states last exactly `BANNER_CYCLES` cycles. The level/world update and the return to PLAY appear in the same cycle.
- Lives decrement is visible in the same cycle that state becomes LOSE_LIFE or GAME_OVER.
- Terminal restart path: start edge → IDLE (1 cycle) → PLAY on the next edge if `start` is still high. Otherwise the FSM waits in IDLE.
- Reset release: the first state change is possible on the first rising `clk` after `reset` returns to 1.

## Test plan
All scenarios use the default parameters.

- **Full win:** hold `start`=1 after reset, then pulse `level_passed` 10 times, each in PLAY. Required: the sequence is levels 0..4 in world 0 (WIN_LEVEL ×4), then WIN_WORLD, then world 1, levels 0..4, then WIN_GAME with level=4, world=1, lives=3. Each banner lasts 4 cycles.
- **Lives:** in PLAY at level 2, pulse `level_failed` 3 times, each in PLAY. Required: lives go 2 → 1 with LOSE_LIFE held 4 cycles each time and level staying at 2; on the third fail, state=GAME_OVER with lives=0.
- **Simultaneous and held inputs:** raise `level_passed` and `level_failed` in the same cycle. Required: WIN_LEVEL and lives unchanged. Then hold `level_passed` high through the banner. Required: after return to PLAY, no further transition.
- **Ignored edges:** pulse `level_passed` during WIN_LEVEL. Required: banner still lasts 4 cycles and level increments by exactly 1.
- **Restart:** in GAME_OVER, raise `start`. Required: IDLE with level=0, world=0, lives=3, then PLAY on the next cycle.
- **Mid-operation reset:** assert `reset`=0 during WIN_WORLD counter=2. Required: immediately state=0, level=0, world=0, lives=3, banner=0 and playing=0.
